// File: rtl/vedic_mac_acc.sv
// Signed int8 multiply-accumulate with a Vedic 8x8 multiplier, valid/ready in/out streams.
// Optional saturation on accumulator overflow when VEDIC_MAC_SAT_EN is defined.

module vedic8_x_8_sc (
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] p
);
  logic [7:0]  ua, ub;
  logic [7:0]  q0, q1, q2, q3;
  logic [8:0]  mid;
  logic [15:0] mag;
  logic        neg;

  // Sign-magnitude: |-128| = 128 still fits in 8 unsigned bits, so (-128)^2 is exact.
  always_comb begin
    ua  = a[7] ? (~a + 8'd1) : a;
    ub  = b[7] ? (~b + 8'd1) : b;
    neg = a[7] ^ b[7];
    q0  = {4'b0, ua[3:0]} * {4'b0, ub[3:0]};
    q1  = {4'b0, ua[7:4]} * {4'b0, ub[3:0]};
    q2  = {4'b0, ua[3:0]} * {4'b0, ub[7:4]};
    q3  = {4'b0, ua[7:4]} * {4'b0, ub[7:4]};
    mid = {1'b0, q1} + {1'b0, q2};
    mag = {q3, q0} + {3'b0, mid, 4'b0};
    p   = neg ? -$signed(mag) : $signed(mag);
  end
endmodule

module vedic_mac_acc #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       in_a,
  input  logic signed [7:0]       in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0]        out_count,
  output logic                    overflow,
  output logic                    busy
);
  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    accept, hs;
  logic signed [7:0]       a_p1, b_p1;
  logic                    last_p1, vld_p1;
  logic signed [15:0]      prod;
  logic signed [15:0]      p_p2;
  logic                    last_p2, vld_p2;
  logic signed [ACC_W-1:0] acc, p_ext, sum, acc_nxt;
  logic [CNT_W-1:0]        count;
  logic                    ovf, add_ovf;

  function automatic logic ovf_det(input logic signed [ACC_W-1:0] x,
                                   input logic signed [ACC_W-1:0] y,
                                   input logic signed [ACC_W-1:0] s);
    return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
  endfunction

`ifdef VEDIC_MAC_SAT_EN
  function automatic logic signed [ACC_W-1:0] sat_val(input logic signed [ACC_W-1:0] x,
                                                      input logic signed [ACC_W-1:0] s,
                                                      input logic                    ov);
    if (ov)
      return x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s;
  endfunction
`endif

  assign accept = in_valid && in_ready;
  assign hs     = out_valid && out_ready;

  // S1: operand capture
  always_ff @(posedge clk) begin
    if (accept && !clr) begin
      a_p1 <= in_a;
      b_p1 <= in_b;
    end
  end

  vedic8_x_8_sc u_mul (.a(a_p1), .b(b_p1), .p(prod));

  // S2: product register
  always_ff @(posedge clk) begin
    if (vld_p1) p_p2 <= prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else if (clr) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      vld_p1  <= accept;
      last_p1 <= accept && in_last;
      vld_p2  <= vld_p1;
      last_p2 <= vld_p1 && last_p1;
    end
  end

  always_comb begin
    p_ext   = ACC_W'(p_p2);
    sum     = acc + p_ext;
    add_ovf = ovf_det(acc, p_ext, sum);
`ifdef VEDIC_MAC_SAT_EN
    acc_nxt = sat_val(acc, sum, add_ovf);
`else
    acc_nxt = sum;
`endif
  end

  // S3: accumulate; output handshake and clr both start a fresh vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr || hs) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (vld_p2) begin
      acc   <= acc_nxt;
      count <= (&count) ? count : count + CNT_W'(1);
      ovf   <= ovf | add_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (vld_p2 && last_p2) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
    if (clr) state_nxt = ACC;
  end

  assign out_acc   = acc;
  assign out_count = count;
  assign overflow  = ovf;
  assign busy      = vld_p1 || vld_p2 || (state != ACC);
endmodule
